tx_msg_sched: RTL and testbench
===============================

TX_MSG_SCHED -- requirements
Module: tx_msg_sched

Interface
REQ-001 Parameter NUM_MSGS, default 4: number of message-table slots arbitrated; SHALL be >= 2.
REQ-002 Parameter DEPTH, default 8: downstream switch input-buffer depth in flits; initial and maximum credit count.
REQ-003 Port clk, input, 1: sole clock; all state SHALL update on its rising edge.
REQ-004 Port n_rst, input, 1: reset, asynchronous, active-low.
REQ-005 Port trigger_send, input, NUM_MSGS: per-slot send request pulses from the message table.
REQ-006 Port send_valid, output, 1: a granted slot is offered to the TX FSM.
REQ-007 Port send_id, output, $clog2(NUM_MSGS): granted slot index; valid while send_valid=1 and in BUSY.
REQ-008 Port send_ready, input, 1: TX FSM accepts the offered slot.
REQ-009 Port send_done, input, 1: TX FSM finished the last flit of the current packet (1-cycle pulse).
REQ-010 Port msg_done, output, NUM_MSGS: one-hot 1-cycle completion pulse back to the message table.
REQ-011 Port flit_sent, input, 1: one flit pushed into switch input port 0 this cycle.
REQ-012 Port credit_return, input, 1: downstream freed one buffer entry this cycle.
REQ-013 Port credits, output, $clog2(DEPTH+1): current credit count.
REQ-014 Port flit_ok, output, 1: TX FSM may push a flit this cycle.
REQ-015 Port busy, output, 1: high in GRANT or BUSY.

Function
REQ-016 pending[NUM_MSGS] register: bit i SHALL be set the cycle after trigger_send[i]=1; a trigger on an already-set bit is absorbed (no queueing of duplicates).
REQ-017 FSM states SHALL be IDLE, GRANT, BUSY.
REQ-018 IDLE: if |pending, select winner round-robin starting at rr_ptr (first set bit at index >= rr_ptr, wrapping), latch it into send_id, go to GRANT; else stay.
REQ-019 GRANT: send_valid=1, send_id stable; on send_ready=1 clear pending[send_id] and go to BUSY; otherwise hold with send_valid=1 indefinitely.
REQ-020 BUSY: send_valid=0; on send_done=1 pulse msg_done[send_id] for that cycle only, set rr_ptr = (send_id+1) mod NUM_MSGS, go to IDLE.
REQ-021 send_done outside BUSY and send_ready outside GRANT SHALL be ignored.
REQ-022 Simultaneous trigger_send[i] and clear of pending[i] (GRANT acceptance of slot i): set wins; pending[i] stays 1 and slot i is re-sent later.
REQ-023 Latency: trigger at cycle t with FSM idle -> send_valid high from cycle t+2; send_done at cycle u -> msg_done at cycle u (combinational from state), next send_valid no earlier than u+2.
REQ-024 Credits: credits-1 on flit_sent only, +1 on credit_return only, unchanged on both or neither.
REQ-025 Credits SHALL saturate: credit_return at DEPTH leaves DEPTH; flit_sent at 0 leaves 0.
REQ-026 flit_ok = (credits != 0) && state==BUSY, combinational.
REQ-027 Credit logic SHALL run independently of FSM state.

Reset
REQ-028 While n_rst=0: state=IDLE, pending=0, rr_ptr=0, send_id=0, credits=DEPTH; outputs send_valid=0, msg_done=0, flit_ok=0, busy=0.
REQ-029 Reset assertion mid-packet SHALL abort immediately; no msg_done is issued for the aborted slot and its pending bit is lost.

Verification
REQ-030 Single: trigger_send=4'b0100 at t -> send_valid=1, send_id=2 at t+2; send_ready at t+3 -> BUSY; send_done at t+6 -> msg_done=4'b0100 at t+6 only, busy=0 at t+7.
REQ-031 Round-robin: trigger 4'b1011 together -> grant order 0,1,3; after completing 3, new trigger 4'b0001 -> grant 0.
REQ-032 Backpressure: hold send_ready=0 for 10 cycles in GRANT -> send_valid and send_id stable throughout, pending unchanged.
REQ-033 Credits (DEPTH=8): 8 flit_sent pulses -> credits=0, flit_ok=0; further flit_sent -> stays 0; simultaneous flit_sent+credit_return -> unchanged; 9 credit_return from 0 -> 8.
REQ-034 Re-trigger: trigger slot 1 in the cycle of its acceptance -> slot 1 sent twice, two msg_done[1] pulses.
REQ-035 Reset mid-BUSY: n_rst low for 1 cycle -> all outputs at reset values, credits=8, no msg_done pulse.

Source files
------------

// File: rtl/tx_msg_sched.sv
// rtl/tx_msg_sched.sv - round-robin message send scheduler with downstream credit tracking
//
// Purpose: collects per-slot send requests from the message table, grants one
// slot at a time to the TX FSM (IDLE -> GRANT -> BUSY), reports completion
// back to the table, and tracks credits for the downstream switch input buffer.
//
// Ports:
//   clk           - clock, all state on rising edge
//   n_rst         - asynchronous active-low reset
//   trigger_send  - per-slot send request pulses
//   send_valid    - granted slot offered to TX FSM (GRANT state)
//   send_id       - granted slot index
//   send_ready    - TX FSM accepts the offered slot
//   send_done     - TX FSM finished the packet (pulse)
//   msg_done      - one-hot completion pulse to the message table
//   flit_sent     - one flit pushed downstream this cycle
//   credit_return - downstream freed one buffer entry this cycle
//   credits       - current credit count
//   flit_ok       - TX FSM may push a flit this cycle
//   busy          - scheduler in GRANT or BUSY
module tx_msg_sched #(
  parameter int NUM_MSGS = 4,
  parameter int DEPTH    = 8
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic [NUM_MSGS-1:0]          trigger_send,
  output logic                         send_valid,
  output logic [$clog2(NUM_MSGS)-1:0]  send_id,
  input  logic                         send_ready,
  input  logic                         send_done,
  output logic [NUM_MSGS-1:0]          msg_done,
  input  logic                         flit_sent,
  input  logic                         credit_return,
  output logic [$clog2(DEPTH+1)-1:0]   credits,
  output logic                         flit_ok,
  output logic                         busy
);

  localparam int ID_W  = $clog2(NUM_MSGS);
  localparam int ID_W1 = ID_W + 1;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  state_t              r_state;
  logic [NUM_MSGS-1:0] r_pending;
  logic [ID_W-1:0]     r_send_id;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [CW-1:0]       r_credits;

  logic                w_any;
  logic [ID_W-1:0]     w_win;
  logic [ID_W1-1:0]    w_sum;
  logic [NUM_MSGS-1:0] w_id_onehot;
  logic [NUM_MSGS-1:0] w_clr;
  logic [ID_W-1:0]     w_next_ptr;
  logic [CW-1:0]       w_cred_next;

  assign w_any       = |r_pending;
  assign w_id_onehot = NUM_MSGS'(1) << r_send_id;
  assign w_clr       = (r_state == S_GRANT && send_ready) ? w_id_onehot : '0;
  assign w_next_ptr  = (r_send_id == ID_W'(NUM_MSGS - 1)) ? '0 : r_send_id + ID_W'(1);

  // Scan offsets from farthest to nearest so the first set bit at or after
  // rr_ptr (with wrap) is the last assignment and therefore wins.
  always_comb begin
    w_win = '0;
    w_sum = '0;
    for (int k = NUM_MSGS - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + ID_W1'(k);
      if (w_sum >= ID_W1'(NUM_MSGS)) begin
        w_sum = w_sum - ID_W1'(NUM_MSGS);
      end
      if (r_pending[w_sum[ID_W-1:0]]) begin
        w_win = w_sum[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_send_id <= '0;
      r_rr_ptr  <= '0;
    end else begin
      // A new trigger overrides the acceptance clear, so a slot re-triggered
      // while being accepted is sent again later.
      r_pending <= (r_pending & ~w_clr) | trigger_send;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_send_id <= w_win;
            r_state   <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (send_ready) begin
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (send_done) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Credits track the downstream buffer regardless of scheduler state.
  always_comb begin
    w_cred_next = r_credits;
    if (flit_sent && !credit_return && r_credits != '0) begin
      w_cred_next = r_credits - CW'(1);
    end else if (credit_return && !flit_sent && r_credits != CW'(DEPTH)) begin
      w_cred_next = r_credits + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_credits <= CW'(DEPTH);
    end else begin
      r_credits <= w_cred_next;
    end
  end

  assign send_valid = (r_state == S_GRANT);
  assign send_id    = r_send_id;
  assign busy       = (r_state != S_IDLE);
  assign msg_done   = (r_state == S_BUSY && send_done) ? w_id_onehot : '0;
  assign credits    = r_credits;
  assign flit_ok    = (r_credits != '0) && (r_state == S_BUSY);

endmodule

// File: tb/tb_tx_msg_sched.sv
// tb/tb_tx_msg_sched.sv - directed self-checking bench for tx_msg_sched
module tb_tx_msg_sched;

  logic       clk;
  logic       n_rst;
  logic [3:0] trigger_send;
  logic       send_valid;
  logic [1:0] send_id;
  logic       send_ready;
  logic       send_done;
  logic [3:0] msg_done;
  logic       flit_sent;
  logic       credit_return;
  logic [3:0] credits;
  logic       flit_ok;
  logic       busy;

  int checks = 0;
  int errors = 0;

  tx_msg_sched #(.NUM_MSGS(4), .DEPTH(8)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .trigger_send  (trigger_send),
    .send_valid    (send_valid),
    .send_id       (send_id),
    .send_ready    (send_ready),
    .send_done     (send_done),
    .msg_done      (msg_done),
    .flit_sent     (flit_sent),
    .credit_return (credit_return),
    .credits       (credits),
    .flit_ok       (flit_ok),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Move to 2 time units after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_grant(input logic [1:0] exp_id, input string tag);
    for (int i = 0; i < 20 && !send_valid; i++) cyc();
    #1;
    chk({tag, "_valid"}, {31'd0, send_valid}, 32'd1);
    chk({tag, "_id"}, {30'd0, send_id}, {30'd0, exp_id});
  endtask

  task automatic accept(input string tag);
    send_ready = 1'b1;
    cyc();
    send_ready = 1'b0;
    #1;
    chk({tag, "_busy_valid"}, {31'd0, send_valid}, 32'd0);
    chk({tag, "_busy_busy"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic finish(input logic [3:0] exp_done, input string tag);
    send_done = 1'b1;
    #1;
    chk({tag, "_msg_done"}, {28'd0, msg_done}, {28'd0, exp_done});
    cyc();
    send_done = 1'b0;
    #1;
    chk({tag, "_msg_done_clr"}, {28'd0, msg_done}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic trig(input logic [3:0] v);
    cyc();
    trigger_send = v;
    cyc();
    trigger_send = 4'b0000;
  endtask

  initial begin
    n_rst = 1'b0;
    trigger_send = '0;
    send_ready = 1'b0;
    send_done = 1'b0;
    flit_sent = 1'b0;
    credit_return = 1'b0;

    // Reset values
    cyc();
    #1;
    chk("rst_valid", {31'd0, send_valid}, 32'd0);
    chk("rst_id", {30'd0, send_id}, 32'd0);
    chk("rst_msg_done", {28'd0, msg_done}, 32'd0);
    chk("rst_flit_ok", {31'd0, flit_ok}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_credits", {28'd0, credits}, 32'd8);
    cyc();
    n_rst = 1'b1;

    // Single send latency: trigger at t
    cyc();
    trigger_send = 4'b0100;
    #1;
    chk("single_t_valid", {31'd0, send_valid}, 32'd0);
    cyc();                                  // t+1
    trigger_send = 4'b0000;
    #1;
    chk("single_t1_valid", {31'd0, send_valid}, 32'd0);
    cyc();                                  // t+2
    #1;
    chk("single_t2_valid", {31'd0, send_valid}, 32'd1);
    chk("single_t2_id", {30'd0, send_id}, 32'd2);
    chk("single_t2_busy", {31'd0, busy}, 32'd1);
    cyc();                                  // t+3
    accept("single");                       // checks at t+4
    chk("single_flit_ok", {31'd0, flit_ok}, 32'd1);
    cyc();                                  // t+5
    #1;
    chk("single_t5_msg_done", {28'd0, msg_done}, 32'd0);
    cyc();                                  // t+6
    finish(4'b0100, "single");              // msg_done at t+6, idle at t+7

    // Reset clears rr_ptr before the round-robin sequence
    cyc();
    n_rst = 1'b0;
    cyc();
    n_rst = 1'b1;

    // Round-robin 1011 -> 0,1,3 then 0001 -> 0
    trig(4'b1011);
    wait_grant(2'd0, "rr0");
    accept("rr0");
    finish(4'b0001, "rr0");
    wait_grant(2'd1, "rr1");
    accept("rr1");
    finish(4'b0010, "rr1");
    wait_grant(2'd3, "rr3");
    accept("rr3");
    finish(4'b1000, "rr3");
    trig(4'b0001);
    wait_grant(2'd0, "rr_wrap");
    accept("rr_wrap");
    finish(4'b0001, "rr_wrap");

    // Backpressure: rr_ptr=1, pending {1,2}; hold slot 1 in GRANT
    trig(4'b0110);
    wait_grant(2'd1, "bp");
    for (int i = 0; i < 10; i++) begin
      cyc();
      #1;
      chk("bp_hold_valid", {31'd0, send_valid}, 32'd1);
      chk("bp_hold_id", {30'd0, send_id}, 32'd1);
    end
    accept("bp");
    finish(4'b0010, "bp");
    wait_grant(2'd2, "bp_pending");
    accept("bp_pending");
    finish(4'b0100, "bp_pending");

    // Credits while holding BUSY (rr_ptr=3, slot 0 wraps)
    trig(4'b0001);
    wait_grant(2'd0, "cr");
    accept("cr");
    chk("cr_full", {28'd0, credits}, 32'd8);
    chk("cr_full_ok", {31'd0, flit_ok}, 32'd1);
    flit_sent = 1'b1;
    repeat (8) cyc();
    #1;
    chk("cr_empty", {28'd0, credits}, 32'd0);
    chk("cr_empty_ok", {31'd0, flit_ok}, 32'd0);
    cyc();
    #1;
    chk("cr_sat_low", {28'd0, credits}, 32'd0);
    credit_return = 1'b1;
    cyc();
    #1;
    chk("cr_both_zero", {28'd0, credits}, 32'd0);
    flit_sent = 1'b0;
    cyc();
    #1;
    chk("cr_ret1", {28'd0, credits}, 32'd1);
    chk("cr_ret1_ok", {31'd0, flit_ok}, 32'd1);
    flit_sent = 1'b1;
    cyc();
    #1;
    chk("cr_both_mid", {28'd0, credits}, 32'd1);
    flit_sent = 1'b0;
    repeat (7) cyc();
    #1;
    chk("cr_ret8", {28'd0, credits}, 32'd8);
    cyc();
    #1;
    chk("cr_sat_high", {28'd0, credits}, 32'd8);
    credit_return = 1'b0;
    finish(4'b0001, "cr");

    // Re-trigger slot 1 in its acceptance cycle -> sent twice
    trig(4'b0010);
    wait_grant(2'd1, "re1");
    send_ready = 1'b1;
    trigger_send = 4'b0010;
    cyc();
    send_ready = 1'b0;
    trigger_send = 4'b0000;
    #1;
    chk("re1_busy", {31'd0, busy}, 32'd1);
    finish(4'b0010, "re1");
    wait_grant(2'd1, "re2");
    accept("re2");
    finish(4'b0010, "re2");

    // Reset during BUSY with send_done asserted
    trig(4'b1000);
    wait_grant(2'd3, "ab");
    accept("ab");
    flit_sent = 1'b1;
    repeat (2) cyc();
    flit_sent = 1'b0;
    #1;
    chk("ab_credits_pre", {28'd0, credits}, 32'd6);
    send_done = 1'b1;
    n_rst = 1'b0;
    #1;
    chk("ab_msg_done", {28'd0, msg_done}, 32'd0);
    chk("ab_busy", {31'd0, busy}, 32'd0);
    chk("ab_valid", {31'd0, send_valid}, 32'd0);
    chk("ab_flit_ok", {31'd0, flit_ok}, 32'd0);
    chk("ab_credits", {28'd0, credits}, 32'd8);
    chk("ab_id", {30'd0, send_id}, 32'd0);
    cyc();
    n_rst = 1'b1;
    send_done = 1'b0;
    repeat (3) cyc();
    #1;
    chk("ab_after_valid", {31'd0, send_valid}, 32'd0);
    chk("ab_after_busy", {31'd0, busy}, 32'd0);
    chk("ab_after_msg_done", {28'd0, msg_done}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
